// File: rtl/lsu_rsp_gather.sv
// lsu_rsp_gather: merges out-of-order per-lane load responses into one full-width writeback per tag
module lsu_rsp_gather #(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_DEPTH  = 8,
  parameter int META_WIDTH = 48,
  parameter int IN_ORDER   = 0,
  parameter int TIMEOUT    = 0,
  localparam int TAG_BITS  = $clog2(TAG_DEPTH),
  localparam int DW        = NUM_LANES * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  input  logic [NUM_LANES-1:0]  alloc_mask,
  input  logic [META_WIDTH-1:0] alloc_meta,
  output logic [TAG_BITS-1:0]   alloc_tag,
  input  logic                  rsp_valid,
  input  logic [TAG_BITS-1:0]   rsp_tag,
  input  logic [NUM_LANES-1:0]  rsp_mask,
  input  logic [DW-1:0]         rsp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TAG_BITS-1:0]   out_tag,
  output logic [NUM_LANES-1:0]  out_mask,
  output logic [META_WIDTH-1:0] out_meta,
  output logic [DW-1:0]         out_data,
  output logic                  empty,
  output logic                  full,
  output logic [TAG_BITS:0]     count,
  output logic                  err_unexpected,
  output logic                  err_timeout
);
  typedef enum logic [1:0] {FREE, PEND, DONE, HELD} state_e;
  state_e                st   [TAG_DEPTH];
  logic [NUM_LANES-1:0]  rem  [TAG_DEPTH];
  logic [NUM_LANES-1:0]  msk  [TAG_DEPTH];
  logic [META_WIDTH-1:0] meta [TAG_DEPTH];
  logic [DW-1:0]         data [TAG_DEPTH];
  logic [TAG_BITS-1:0]   ord  [TAG_DEPTH];
  logic [TAG_BITS-1:0]   head, tail, sel;
  logic                  sel_ok, a_hs, a_fire, o_fire, load, r_pend, r_bad;
  logic [NUM_LANES-1:0]  r_rem;
  assign a_hs   = alloc_valid && alloc_ready;
  assign a_fire = a_hs && |alloc_mask;
  assign o_fire = out_valid && out_ready;
  assign load   = !out_valid || out_ready;
  assign r_pend = st[rsp_tag] == PEND;
  assign r_rem  = rem[rsp_tag] & ~rsp_mask;
  assign r_bad  = rsp_valid && (!r_pend || |(rsp_mask & ~rem[rsp_tag]));
  assign empty  = count == '0;
  assign full   = count == (TAG_BITS+1)'(TAG_DEPTH);
  always_comb begin
    alloc_ready = 1'b0;
    alloc_tag   = '0;
    for (int i = TAG_DEPTH-1; i >= 0; i--)
      if (st[i] == FREE) begin
        alloc_ready = 1'b1;
        alloc_tag   = TAG_BITS'(i);
      end
  end
  // in-order mode only ever offers the oldest live allocation
  always_comb begin
    sel_ok = 1'b0;
    sel    = '0;
    for (int i = TAG_DEPTH-1; i >= 0; i--)
      if (st[i] == DONE) begin
        sel_ok = 1'b1;
        sel    = TAG_BITS'(i);
      end
    if (IN_ORDER != 0) begin
      sel    = ord[head];
      sel_ok = st[ord[head]] == DONE;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < TAG_DEPTH; i++) begin
        st[i]   <= FREE;
        rem[i]  <= '0;
        msk[i]  <= '0;
        meta[i] <= '0;
        data[i] <= '0;
        ord[i]  <= '0;
      end
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      out_valid      <= 1'b0;
      out_tag        <= '0;
      out_mask       <= '0;
      out_meta       <= '0;
      out_data       <= '0;
      err_unexpected <= 1'b0;
    end else begin
      if (rsp_valid && r_pend) begin
        rem[rsp_tag] <= r_rem;
        if (r_rem == '0) st[rsp_tag] <= DONE;
        for (int j = 0; j < NUM_LANES; j++)
          if (rsp_mask[j] && rem[rsp_tag][j])
            data[rsp_tag][j*DATA_WIDTH +: DATA_WIDTH] <= rsp_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
      if (a_fire) begin
        st[alloc_tag]   <= PEND;
        rem[alloc_tag]  <= alloc_mask;
        msk[alloc_tag]  <= alloc_mask;
        meta[alloc_tag] <= alloc_meta;
        data[alloc_tag] <= '0;
        ord[tail]       <= alloc_tag;
        tail            <= tail + TAG_BITS'(1);
      end
      if (load) begin
        out_valid <= sel_ok;
        if (sel_ok) begin
          st[sel]  <= HELD;
          out_tag  <= sel;
          out_mask <= msk[sel];
          out_meta <= meta[sel];
          out_data <= data[sel];
          if (IN_ORDER != 0) head <= head + TAG_BITS'(1);
        end
      end
      if (o_fire) st[out_tag] <= FREE;
      count          <= count + (TAG_BITS+1)'(a_fire) - (TAG_BITS+1)'(o_fire);
      err_unexpected <= err_unexpected | r_bad;
    end
  if (TIMEOUT > 0) begin : g_wd
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wd;
    logic          quiet;
    assign quiet = !(a_hs || rsp_valid || o_fire || empty);
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        wd          <= '0;
        err_timeout <= 1'b0;
      end else begin
        wd          <= !quiet ? '0 : (wd == WW'(TIMEOUT) ? wd : wd + WW'(1));
        err_timeout <= err_timeout | (quiet && wd == WW'(TIMEOUT - 1));
      end
  end else begin : g_no_wd
    assign err_timeout = 1'b0;
  end
endmodule

// File: tb/tb_lsu_rsp_gather.sv
// tb_lsu_rsp_gather: directed and random checks of both release modes against a spec-level model
module tb_lsu_rsp_gather;
  localparam int L = 4, W = 32, T = 8, M = 48, TO = 16;
  logic         clk = 1'b0, reset_n = 1'b0;
  logic         alloc_valid = 1'b0, rsp_valid = 1'b0, out_ready = 1'b0;
  logic [3:0]   alloc_mask = '0, rsp_mask = '0;
  logic [47:0]  alloc_meta = '0;
  logic [2:0]   rsp_tag = '0;
  logic [127:0] rsp_data = '0;
  logic         ard [2], ov [2], emp [2], ful [2], erru [2], errt [2];
  logic [2:0]   atag [2], otag [2];
  logic [3:0]   omask [2], cnt [2];
  logic [47:0]  ometa [2];
  logic [127:0] odat [2];
  int n_chk = 0, n_fail = 0;
  // reference model: entry status 0 free, 1 pending, 2 done, 3 held at output
  int           mst [2][T], mseq [2][T], seqc [2], motag [2], mcnt [2], mwd [2];
  logic [3:0]   mrem [2][T], mmsk [2][T], momask [2];
  logic [47:0]  mmeta [2][T], mometa [2];
  logic [127:0] mdat [2][T], modat [2];
  bit           mov [2], merru [2], merrt [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    lsu_rsp_gather #(.NUM_LANES(L), .DATA_WIDTH(W), .TAG_DEPTH(T), .META_WIDTH(M),
                     .IN_ORDER(g), .TIMEOUT(TO)) u (
      .clk(clk), .reset_n(reset_n),
      .alloc_valid(alloc_valid), .alloc_ready(ard[g]), .alloc_mask(alloc_mask),
      .alloc_meta(alloc_meta), .alloc_tag(atag[g]),
      .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_mask(rsp_mask), .rsp_data(rsp_data),
      .out_valid(ov[g]), .out_ready(out_ready), .out_tag(otag[g]), .out_mask(omask[g]),
      .out_meta(ometa[g]), .out_data(odat[g]),
      .empty(emp[g]), .full(ful[g]), .count(cnt[g]),
      .err_unexpected(erru[g]), .err_timeout(errt[g]));
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int lowest_free(input int m);
    for (int i = 0; i < T; i++) if (mst[m][i] == 0) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < T; i++) begin
        mst[m][i] = 0; mseq[m][i] = 0; mrem[m][i] = '0; mmsk[m][i] = '0;
        mmeta[m][i] = '0; mdat[m][i] = '0;
      end
      seqc[m] = 0; motag[m] = 0; mcnt[m] = 0; mwd[m] = 0; momask[m] = '0;
      mometa[m] = '0; modat[m] = '0; mov[m] = 0; merru[m] = 0; merrt[m] = 0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      int at, sel, old, t;
      bit hs, of, ld;
      at = lowest_free(m); sel = -1; old = -1;
      hs = alloc_valid && at >= 0; of = mov[m] && out_ready; ld = !mov[m] || out_ready;
      if (m == 0) begin
        for (int i = 0; i < T; i++) if (sel < 0 && mst[m][i] == 2) sel = i;
      end else begin
        for (int i = 0; i < T; i++)
          if ((mst[m][i] == 1 || mst[m][i] == 2) && (old < 0 || mseq[m][i] < mseq[m][old])) old = i;
        if (old >= 0 && mst[m][old] == 2) sel = old;
      end
      if (hs || rsp_valid || of || mcnt[m] == 0) mwd[m] = 0;
      else if (mwd[m] < TO) begin
        mwd[m]++;
        if (mwd[m] == TO) merrt[m] = 1;
      end
      if (rsp_valid) begin
        t = int'(rsp_tag);
        if (mst[m][t] == 1) begin
          for (int j = 0; j < L; j++)
            if (rsp_mask[j]) begin
              if (mrem[m][t][j]) begin
                mdat[m][t][j*W +: W] = rsp_data[j*W +: W];
                mrem[m][t][j] = 1'b0;
              end else merru[m] = 1;
            end
          if (mrem[m][t] == '0) mst[m][t] = 2;
        end else merru[m] = 1;
      end
      if (of) begin mst[m][motag[m]] = 0; mcnt[m]--; end
      if (ld) begin
        mov[m] = sel >= 0;
        if (sel >= 0) begin
          motag[m] = sel; momask[m] = mmsk[m][sel]; mometa[m] = mmeta[m][sel];
          modat[m] = mdat[m][sel]; mst[m][sel] = 3;
        end
      end
      if (hs && alloc_mask != '0) begin
        mst[m][at] = 1; mrem[m][at] = alloc_mask; mmsk[m][at] = alloc_mask;
        mmeta[m][at] = alloc_meta; mdat[m][at] = '0; mseq[m][at] = seqc[m]++; mcnt[m]++;
      end
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      int at;
      string p;
      at = lowest_free(m);
      p = $sformatf("u%0d.", m);
      chk({p, "alloc_ready"}, 128'(ard[m]), 128'(at >= 0));
      if (at >= 0) chk({p, "alloc_tag"}, 128'(atag[m]), 128'(at));
      chk({p, "out_valid"}, 128'(ov[m]), 128'(mov[m]));
      if (mov[m]) begin
        chk({p, "out_tag"}, 128'(otag[m]), 128'(motag[m]));
        chk({p, "out_mask"}, 128'(omask[m]), 128'(momask[m]));
        chk({p, "out_meta"}, 128'(ometa[m]), 128'(mometa[m]));
        chk({p, "out_data"}, odat[m], modat[m]);
      end
      chk({p, "empty"}, 128'(emp[m]), 128'(mcnt[m] == 0));
      chk({p, "full"}, 128'(ful[m]), 128'(mcnt[m] == T));
      chk({p, "count"}, 128'(cnt[m]), 128'(mcnt[m]));
      chk({p, "err_unexpected"}, 128'(erru[m]), 128'(merru[m]));
      chk({p, "err_timeout"}, 128'(errt[m]), 128'(merrt[m]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    alloc_valid = 1'b0; rsp_valid = 1'b0;
  endtask

  task automatic do_alloc(input logic [3:0] mk, input logic [47:0] mt);
    idle(); alloc_valid = 1'b1; alloc_mask = mk; alloc_meta = mt; step(); idle();
  endtask

  task automatic do_rsp(input int t, input logic [3:0] mk, input logic [127:0] d);
    idle(); rsp_valid = 1'b1; rsp_tag = 3'(t); rsp_mask = mk; rsp_data = d; step(); idle();
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1 model_reset();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("rst.u%0d.out_valid", m), 128'(ov[m]), 128'(0));
      chk($sformatf("rst.u%0d.count", m), 128'(cnt[m]), 128'(0));
      chk($sformatf("rst.u%0d.empty", m), 128'(emp[m]), 128'(1));
    end
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
    idle();
  endtask

  initial begin
    logic [127:0] d0, d1, dx, dz;
    int q0[$], q1[$];
    int e0[3] = '{2, 0, 1};
    int e1[3] = '{0, 1, 2};
    model_reset();
    do_reset();
    for (int m = 0; m < 2; m++) begin
      chk("rst.out_tag", 128'(otag[m]), 128'(0));
      chk("rst.out_mask", 128'(omask[m]), 128'(0));
      chk("rst.out_meta", 128'(ometa[m]), 128'(0));
      chk("rst.out_data", odat[m], 128'(0));
      chk("rst.alloc_tag", 128'(atag[m]), 128'(0));
    end
    // four lanes gathered from three fragments
    d0 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    do_alloc(4'b1111, 48'h123);
    do_rsp(0, 4'b0001, d0);
    do_rsp(0, 4'b0100, d0);
    do_rsp(0, 4'b1010, d0);
    chk("gather.early", 128'(ov[0]), 128'(0));
    step();
    for (int m = 0; m < 2; m++) begin
      chk("gather.valid", 128'(ov[m]), 128'(1));
      chk("gather.data", odat[m], d0);
      chk("gather.mask", 128'(omask[m]), 128'(4'b1111));
      chk("gather.meta", 128'(ometa[m]), 128'(48'h123));
      chk("gather.tag", 128'(otag[m]), 128'(0));
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("gather.single", 128'(ov[0]), 128'(0));
    // full table
    do_reset();
    for (int i = 0; i < T; i++) begin
      chk("full.alloc_tag", 128'(atag[0]), 128'(i));
      do_alloc(4'b0001, 48'(i));
    end
    for (int m = 0; m < 2; m++) begin
      chk("full.full", 128'(ful[m]), 128'(1));
      chk("full.ready", 128'(ard[m]), 128'(0));
      chk("full.count", 128'(cnt[m]), 128'(8));
    end
    do_rsp(5, 4'b0001, 128'h55);
    step();
    chk("full.out_tag", 128'(otag[0]), 128'(5));
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("full.realloc_tag", 128'(atag[0]), 128'(5));
    chk("full.not_full", 128'(ful[0]), 128'(0));
    // release order in both modes
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) do_alloc(4'b0001, 48'(i));
    for (int s = 1; s <= 8; s++) begin
      if (s == 1) do_rsp(2, 4'b0001, 128'h2);
      else if (s == 2) do_rsp(0, 4'b0001, 128'h0);
      else if (s == 5) do_rsp(1, 4'b0001, 128'h1);
      else step();
      if (s == 4) chk("order.stall", 128'(ov[1]), 128'(0));
      if (ov[0]) q0.push_back(int'(otag[0]));
      if (ov[1]) q1.push_back(int'(otag[1]));
    end
    chk("order.n0", 128'(q0.size()), 128'(3));
    chk("order.n1", 128'(q1.size()), 128'(3));
    for (int k = 0; k < 3; k++) begin
      if (k < q0.size()) chk("order.ooo", 128'(q0[k]), 128'(e0[k]));
      if (k < q1.size()) chk("order.inorder", 128'(q1[k]), 128'(e1[k]));
    end
    out_ready = 1'b0;
    // backpressure
    do_reset();
    d0 = {$urandom, $urandom, $urandom, $urandom};
    d1 = {$urandom, $urandom, $urandom, $urandom};
    do_alloc(4'b0011, 48'hAA);
    do_alloc(4'b0011, 48'hBB);
    do_rsp(0, 4'b0011, d0);
    do_rsp(1, 4'b0011, d1);
    for (int s = 0; s < 5; s++) begin
      step();
      chk("bp.tag", 128'(otag[0]), 128'(0));
      chk("bp.data", odat[0], {64'h0, d0[63:0]});
    end
    out_ready = 1'b1;
    step();
    chk("bp.next_tag", 128'(otag[0]), 128'(1));
    chk("bp.next_data", odat[0], {64'h0, d1[63:0]});
    step();
    chk("bp.drained", 128'(ov[0]), 128'(0));
    out_ready = 1'b0;
    // unexpected responses
    do_reset();
    do_rsp(3, 4'b0001, 128'h3);
    chk("err.free_tag", 128'(erru[0]), 128'(1));
    do_reset();
    dx = 128'h1111_2222_3333_4444;
    dz = 128'h5555_6666_7777_8888;
    do_alloc(4'b0011, 48'h7);
    do_rsp(0, 4'b0001, dx);
    chk("err.clean", 128'(erru[0]), 128'(0));
    do_rsp(0, 4'b0001, dz);
    chk("err.dup_lane", 128'(erru[0]), 128'(1));
    do_rsp(0, 4'b0010, dz);
    step();
    chk("err.data_kept", odat[0], {64'h0, dz[63:32], dx[31:0]});
    do_reset();
    alloc_valid = 1'b1; alloc_mask = 4'b1111; alloc_meta = 48'h9;
    rsp_valid = 1'b1; rsp_tag = 3'd0; rsp_mask = 4'b1111; rsp_data = dx;
    step(); idle();
    chk("err.same_cycle", 128'(erru[1]), 128'(1));
    do_rsp(0, 4'b1111, dz);
    step();
    chk("err.same_cycle_data", odat[0], dz);
    // watchdog
    do_reset();
    do_alloc(4'b0001, 48'h1);
    for (int s = 0; s < TO - 1; s++) step();
    chk("wd.before", 128'(errt[0]), 128'(0));
    step();
    chk("wd.fired", 128'(errt[0]), 128'(1));
    // asynchronous reset mid-operation
    do_reset();
    for (int i = 0; i < 3; i++) do_alloc(4'b0001, 48'(i));
    do_rsp(0, 4'b0001, 128'h1);
    step();
    chk("mid.out_valid", 128'(ov[0]), 128'(1));
    do_reset();
    chk("mid.alloc_tag", 128'(atag[0]), 128'(0));
    do_alloc(4'b0001, 48'h1);
    chk("mid.count", 128'(cnt[0]), 128'(1));
    // random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int cand[$];
      int t;
      logic [3:0] mk;
      if ($urandom_range(599) == 0) do_reset();
      alloc_valid = $urandom_range(1) == 1;
      alloc_mask = 4'($urandom);
      alloc_meta = {16'($urandom), $urandom};
      out_ready = $urandom_range(9) < 7;
      rsp_valid = $urandom_range(9) < 6;
      for (int i = 0; i < T; i++) if (mst[0][i] == 1) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(9) < 8) begin
        t = cand[$urandom_range(cand.size() - 1)];
        mk = mrem[0][t] & 4'($urandom);
        if ($urandom_range(9) == 0) mk = mk | 4'($urandom);
      end else begin
        t = $urandom_range(T - 1);
        mk = 4'($urandom);
      end
      rsp_tag = 3'(t); rsp_mask = mk;
      rsp_data = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
